// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, ACK/NACK levels, address type.
package i2c_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef logic [6:0] i2c_addr_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchronizer for one pad input with registered level and edge pulses.
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the pad level through the synchronizer and derive edge pulses aligned to level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            level  <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
            level  <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~level;
            fall   <= ~sync_q[SYNC_STAGES-1] & level;
        end
    end

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target exposing a small byte-wide register file with an auto-incrementing pointer.
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter i2c_addr_t   DEV_ADDR    = 7'h50,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              wr_strobe,
    output logic [PTR_W-1:0]  wr_index,
    output logic [BYTE_W-1:0] wr_data,
    output logic              busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .reset(reset), .din(scl_i),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .reset(reset), .din(sda_i),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_state_t           state_q, state_n;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_n;
    logic [BYTE_W-1:0]    shreg_q, shreg_n;
    logic                 rw_q, rw_n;
    logic [PTR_W-1:0]     ptr_q, ptr_n, ptr_inc;
    logic                 sda_oe_n, wr_strobe_n, busy_n, reg_we;
    logic [PTR_W-1:0]     wr_index_n;
    logic [BYTE_W-1:0]    wr_data_n, rx_byte;
    logic [BYTE_W-1:0]    regs [NUM_REGS];
    logic                 start_det, stop_det;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REGS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign rx_byte   = {shreg_q[BYTE_W-2:0], sda_lvl};
    assign ptr_inc   = next_ptr(ptr_q);

    // Bus-condition and bit-level sequencing; START/STOP override everything else.
    always_comb begin
        state_n     = state_q;
        bit_cnt_n   = bit_cnt_q;
        shreg_n     = shreg_q;
        rw_n        = rw_q;
        ptr_n       = ptr_q;
        sda_oe_n    = sda_oe;
        wr_strobe_n = 1'b0;
        wr_index_n  = wr_index;
        wr_data_n   = wr_data;
        busy_n      = busy;
        reg_we      = 1'b0;
        if (start_det) begin
            state_n   = ST_ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else if (stop_det) begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WR: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
                        if (bit_cnt_q == BIT_CNT_W'(7)) begin
                            bit_cnt_n = '0;
                            case (state_q)
                                ST_ADDR: begin
                                    rw_n = sda_lvl;
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state_n = ST_ADDR_ACK;
                                        busy_n  = 1'b1;
                                    end else begin
                                        state_n = ST_IDLE;
                                        busy_n  = 1'b0;
                                    end
                                end
                                ST_PTR: begin
                                    ptr_n   = rx_byte[PTR_W-1:0];
                                    state_n = ST_PTR_ACK;
                                end
                                default: begin
                                    reg_we      = 1'b1;
                                    wr_strobe_n = 1'b1;
                                    wr_index_n  = ptr_q;
                                    wr_data_n   = rx_byte;
                                    ptr_n       = ptr_inc;
                                    state_n     = ST_WR_ACK;
                                end
                            endcase
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    // First SCL fall starts the ACK, the second one ends it.
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            sda_oe_n = 1'b0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                shreg_n  = regs[ptr_q] << 1;
                                sda_oe_n = ~regs[ptr_q][7];
                                state_n  = ST_RD;
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_n = ST_PTR;
                            end else begin
                                state_n = ST_WR;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (scl_rise) begin
                        bit_cnt_n = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
                    end else if (scl_fall) begin
                        if (bit_cnt_q == BIT_CNT_W'(8)) begin
                            sda_oe_n = 1'b0;
                            state_n  = ST_RD_ACK;
                        end else begin
                            sda_oe_n = ~shreg_q[7];
                            shreg_n  = shreg_q << 1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    // bit_cnt 9 marks a received master ACK awaiting the next SCL fall.
                    if (scl_rise) begin
                        if (sda_lvl == I2C_ACK) begin
                            bit_cnt_n = BIT_CNT_W'(9);
                        end else begin
                            bit_cnt_n = '0;
                            state_n   = ST_IDLE;
                            busy_n    = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt_q == BIT_CNT_W'(9)) begin
                        ptr_n     = ptr_inc;
                        shreg_n   = regs[ptr_inc] << 1;
                        sda_oe_n  = ~regs[ptr_inc][7];
                        bit_cnt_n = '0;
                        state_n   = ST_RD;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            rw_q      <= 1'b0;
            ptr_q     <= '0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_n;
            bit_cnt_q <= bit_cnt_n;
            shreg_q   <= shreg_n;
            rw_q      <= rw_n;
            ptr_q     <= ptr_n;
            sda_oe    <= sda_oe_n;
            wr_strobe <= wr_strobe_n;
            wr_index  <= wr_index_n;
            wr_data   <= wr_data_n;
            busy      <= busy_n;
        end
    end

    // Register file storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[ptr_q] <= rx_byte;
        end
    end

endmodule
